mem_port_arbiter2: RTL

- Two-requester round-robin arbiter for one shared memory/resource port, e.g. instruction fetch (req0) and data access (req1) sharing a single memory.
- Holds a grant for a whole multi-cycle transaction until the resource signals done.
- Drives the shared-port select and muxes the requester addresses onto the port.
- Includes a watchdog that forcibly releases a stuck grant and flags an error.

---
 rtl/mem_port_arbiter2.sv | 114 +++++++++++
 1 files changed

// File: rtl/mem_port_arbiter2.sv
// Two-requester round-robin arbiter for one shared memory port. A grant is held
// for a whole transaction, and a watchdog releases a grant that never sees done.
module mux2_1 #(
   parameter real DELAY = 0.05
) (
   input  logic a,
   input  logic b,
   input  logic s,
   output logic y
);
   // DELAY annotates timing models only; a negative value is a misconfiguration.
   if (DELAY >= 0.0) begin : g_mux
      assign y = s ? b : a;
   end else begin : g_bad_delay
      assign y = 1'bx;
   end
endmodule

module mem_port_arbiter2 #(
   parameter int  WIDTH   = 64,
   parameter int  TIMEOUT = 16,
   parameter real DELAY   = 0.05
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0,
   input  logic             req1,
   input  logic [WIDTH-1:0] addr0,
   input  logic [WIDTH-1:0] addr1,
   input  logic             done,
   output logic             gnt0,
   output logic             gnt1,
   output logic             sel,
   output logic             port_valid,
   output logic [WIDTH-1:0] addr_out,
   output logic             timeout_err
);
   localparam int WD_W = $clog2(TIMEOUT);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] OWN0 = 2'd1;
   localparam logic [1:0] OWN1 = 2'd2;

   logic [1:0]      state_q, state_d;
   logic            last_q, last_d;
   logic            sel_q, sel_d;
   logic            terr_q, terr_d;
   logic [WD_W-1:0] wdog_q, wdog_d;
   logic            pick1;

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      sel_d   = sel_q;
      wdog_d  = wdog_q;
      terr_d  = 1'b0;
      // On a tie the requester that did not own the port last time wins.
      pick1   = req1 & (~req0 | ~last_q);
      case (state_q)
         IDLE: begin
            if (req0 | req1) begin
               state_d = pick1 ? OWN1 : OWN0;
               last_d  = pick1;
               sel_d   = pick1;
               wdog_d  = '0;
            end
         end
         OWN0, OWN1: begin
            if (done) begin
               state_d = IDLE;
            end else if (wdog_q == WD_MAX) begin
               state_d = IDLE;
               terr_d  = 1'b1;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         sel_q   <= 1'b0;
         wdog_q  <= '0;
         terr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         sel_q   <= sel_d;
         wdog_q  <= wdog_d;
         terr_q  <= terr_d;
      end
   end

   assign gnt0        = (state_q == OWN0);
   assign gnt1        = (state_q == OWN1);
   assign port_valid  = gnt0 | gnt1;
   assign sel         = sel_q;
   assign timeout_err = terr_q;

   // sel only moves on grant entry, so addr_out is stable through IDLE.
   for (genvar i = 0; i < WIDTH; i++) begin : g_addr_mux
      mux2_1 #(.DELAY(DELAY)) u_mux (
         .a(addr0[i]),
         .b(addr1[i]),
         .s(sel_q),
         .y(addr_out[i])
      );
   end
endmodule
